bp_update_scheduler: RTL and testbench

BP_UPDATE_SCHEDULER -- requirements
Module: bp_update_scheduler

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_upd_fifo.sv | 91 +++++++++
 rtl/bp_update_scheduler.sv | 132 +++++++++++++
 tb/tb_bp_update_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch-predictor update scheduler:
//   - default queue depth and predictor entry count
//   - scheduler state encoding {INIT, RUN}
//   - update-queue entry layout {pc, target, taken}
// -----------------------------------------------------------------------------
package bp_pkg;

   localparam int DEPTH_DEFAULT       = 4;
   localparam int BTB_ENTRIES_DEFAULT = 8;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bp_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
   } bp_upd_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// -----------------------------------------------------------------------------
// bp_upd_fifo
// Update queue with two write ports and one read port.
// When both write ports fire in one cycle, entry_1 lands in the earlier slot.
// If only one write port fires, its entry goes to the current write pointer.
// The caller guarantees that the queue never overflows and that pop is only
// requested while the queue is non-empty.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   push_1, entry_1     first (older) write
//   push_2, entry_2     second (younger) write
//   pop                 remove the head entry
//   head                entry at the read pointer (registered storage)
//   occupancy           number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module bp_upd_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_1,
   input  bp_upd_t                  entry_1,
   input  logic                     push_2,
   input  bp_upd_t                  entry_2,
   input  logic                     pop,
   output bp_upd_t                  head,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   bp_upd_t            mem_q [DEPTH];
   bp_upd_t            mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, wr_ptr_nx;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   n_push;
   logic               first_en, second_en;
   bp_upd_t            first_data;

   // Next-state for pointers, count and storage.
   always_comb begin
      n_push     = CNT_W'(push_1) + CNT_W'(push_2);
      first_en   = push_1 | push_2;
      second_en  = push_1 & push_2;
      // A lone slot-2 push still takes the earliest free position.
      first_data = push_1 ? entry_1 : entry_2;
      wr_ptr_nx  = wr_ptr_q + PTR_W'(1'b1);
      // Pointers are PTR_W bits wide, so the additions wrap modulo DEPTH.
      wr_ptr_d   = wr_ptr_q + n_push[PTR_W-1:0];
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      cnt_d      = cnt_q + n_push - CNT_W'(pop);
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (first_en && (wr_ptr_q == PTR_W'(i))) begin
            mem_d[i] = first_data;
         end else if (second_en && (wr_ptr_nx == PTR_W'(i))) begin
            mem_d[i] = entry_2;
         end else begin
            mem_d[i] = mem_q[i];
         end
      end
   end

   // Queue state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign occupancy = cnt_q;

endmodule

// File: rtl/bp_update_scheduler.sv
// -----------------------------------------------------------------------------
// bp_update_scheduler
// Collects resolved branch outcomes from two decode slots, queues them, and
// writes them one per cycle into the predictor tables. After reset it first
// sweeps every predictor entry with a clear write (INIT), then serves the
// queue (RUN).
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   upd_valid/taken/pc/target_1     slot-1 resolved branch
//   upd_valid/taken/pc/target_2     slot-2 resolved branch
//   wr_ready                        predictor tables accept a write
//   wr_valid, wr_clr                write request / request is an init clear
//   wr_taken, wr_pc, wr_target      write payload (wr_pc = entry index in INIT)
//   stall_req                       hold the update inputs upstream
//   occupancy                       current queue count
// -----------------------------------------------------------------------------
module bp_update_scheduler
   import bp_pkg::*;
#(
   parameter int DEPTH       = DEPTH_DEFAULT,
   parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     upd_valid_1,
   input  logic                     upd_taken_1,
   input  logic [31:0]              upd_pc_1,
   input  logic [31:0]              upd_target_1,
   input  logic                     upd_valid_2,
   input  logic                     upd_taken_2,
   input  logic [31:0]              upd_pc_2,
   input  logic [31:0]              upd_target_2,
   input  logic                     wr_ready,
   output logic                     wr_valid,
   output logic                     wr_clr,
   output logic                     wr_taken,
   output logic [31:0]              wr_pc,
   output logic [31:0]              wr_target,
   output logic                     stall_req,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BTB_ENTRIES - 1);

   bp_state_e          state_q, state_d;
   logic [IDX_W-1:0]   init_idx_q, init_idx_d;
   logic               push_1, push_2, pop;
   bp_upd_t            entry_1, entry_2, head;
   logic [CNT_W-1:0]   occ;

   bp_upd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_1    (push_1),
      .entry_1   (entry_1),
      .push_2    (push_2),
      .entry_2   (entry_2),
      .pop       (pop),
      .head      (head),
      .occupancy (occ)
   );

   // Enqueue filtering. stall_req depends only on registered state, and with
   // it low at least two entries are free, so the queue cannot overflow.
   always_comb begin
      stall_req = (state_q == INIT) | (occ >= CNT_W'(DEPTH - 1));
      entry_1   = '{pc: upd_pc_1, target: upd_target_1, taken: upd_taken_1};
      entry_2   = '{pc: upd_pc_2, target: upd_target_2, taken: upd_taken_2};
      push_1    = ~stall_req & upd_valid_1;
      // A taken slot-1 branch means slot 2 was on the wrong path.
      push_2    = ~stall_req & upd_valid_2 & ~(upd_valid_1 & upd_taken_1);
      pop       = (state_q == RUN) & (occ != '0) & wr_ready;
   end

   // FSM next state, init sweep index and write-port outputs.
   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      wr_valid   = 1'b0;
      wr_clr     = 1'b0;
      wr_taken   = 1'b0;
      wr_pc      = 32'h0000_0000;
      wr_target  = 32'h0000_0000;
      case (state_q)
         INIT: begin
            wr_valid = 1'b1;
            wr_clr   = 1'b1;
            wr_pc    = {{(32-IDX_W){1'b0}}, init_idx_q};
            if (wr_ready) begin
               if (init_idx_q == LAST_IDX) begin
                  state_d    = RUN;
                  init_idx_d = '0;
               end else begin
                  init_idx_d = init_idx_q + IDX_W'(1'b1);
               end
            end else begin
               init_idx_d = init_idx_q;
            end
         end
         RUN: begin
            // Head only changes on a pop, so the payload holds under back-pressure.
            wr_valid  = (occ != '0);
            wr_pc     = head.pc;
            wr_target = head.target;
            wr_taken  = head.taken;
         end
         default: begin
            state_d    = INIT;
            init_idx_d = '0;
         end
      endcase
   end

   // FSM and init index registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= INIT;
         init_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
      end
   end

   assign occupancy = occ;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bp_update_scheduler
// Directed self-checking bench for bp_update_scheduler (DEPTH=4, BTB_ENTRIES=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_bp_update_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        upd_valid_1, upd_taken_1;
   logic [31:0] upd_pc_1, upd_target_1;
   logic        upd_valid_2, upd_taken_2;
   logic [31:0] upd_pc_2, upd_target_2;
   logic        wr_ready;
   logic        wr_valid, wr_clr, wr_taken;
   logic [31:0] wr_pc, wr_target;
   logic        stall_req;
   logic [2:0]  occupancy;

   int n_checks = 0;
   int n_pass   = 0;

   bp_update_scheduler #(
      .DEPTH       (4),
      .BTB_ENTRIES (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .upd_valid_1  (upd_valid_1),
      .upd_taken_1  (upd_taken_1),
      .upd_pc_1     (upd_pc_1),
      .upd_target_1 (upd_target_1),
      .upd_valid_2  (upd_valid_2),
      .upd_taken_2  (upd_taken_2),
      .upd_pc_2     (upd_pc_2),
      .upd_target_2 (upd_target_2),
      .wr_ready     (wr_ready),
      .wr_valid     (wr_valid),
      .wr_clr       (wr_clr),
      .wr_taken     (wr_taken),
      .wr_pc        (wr_pc),
      .wr_target    (wr_target),
      .stall_req    (stall_req),
      .occupancy    (occupancy)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic v1, input logic t1, input logic [31:0] pc1, input logic [31:0] tg1,
                          input logic v2, input logic t2, input logic [31:0] pc2, input logic [31:0] tg2);
      upd_valid_1 = v1; upd_taken_1 = t1; upd_pc_1 = pc1; upd_target_1 = tg1;
      upd_valid_2 = v2; upd_taken_2 = t2; upd_pc_2 = pc2; upd_target_2 = tg2;
   endtask

   task automatic clr_upd();
      set_upd(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Expect a live queue head with the given payload and occupancy.
   task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] tg,
                           input logic tk, input logic [2:0] occ);
      chk({tag, "_valid"}, 32'(wr_valid), 32'd1);
      chk({tag, "_clr"},   32'(wr_clr), 32'd0);
      chk({tag, "_pc"},    wr_pc, pc);
      chk({tag, "_tgt"},   wr_target, tg);
      chk({tag, "_taken"}, 32'(wr_taken), 32'(tk));
      chk({tag, "_occ"},   32'(occupancy), 32'(occ));
   endtask

   // Expect the init sweep to present clear writes 0..7 with wr_ready high.
   task automatic run_init(input string tag);
      for (int k = 0; k < 8; k++) begin
         chk({tag, "_valid"}, 32'(wr_valid), 32'd1);
         chk({tag, "_clr"},   32'(wr_clr), 32'd1);
         chk({tag, "_pc"},    wr_pc, 32'(k));
         chk({tag, "_stall"}, 32'(stall_req), 32'd1);
         tick();
      end
      chk({tag, "_done_stall"}, 32'(stall_req), 32'd0);
      chk({tag, "_done_valid"}, 32'(wr_valid), 32'd0);
      chk({tag, "_done_clr"},   32'(wr_clr), 32'd0);
      chk({tag, "_done_occ"},   32'(occupancy), 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      wr_ready = 1'b0;
      clr_upd();
      tick();
      tick();

      // Reset state.
      chk("rst_valid", 32'(wr_valid), 32'd1);
      chk("rst_clr",   32'(wr_clr), 32'd1);
      chk("rst_pc",    wr_pc, 32'd0);
      chk("rst_tgt",   wr_target, 32'd0);
      chk("rst_taken", 32'(wr_taken), 32'd0);
      chk("rst_stall", 32'(stall_req), 32'd1);
      chk("rst_occ",   32'(occupancy), 32'd0);

      // Init sweep; an update offered during INIT must be dropped.
      reset    = 1'b0;
      wr_ready = 1'b1;
      set_upd(1'b1, 1'b0, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 32'hDEB0, 32'h0);
      run_init("init");
      clr_upd();

      // Taken slot 1 squashes slot 2.
      wr_ready = 1'b0;
      set_upd(1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h999, 32'h998);
      tick();
      clr_upd();
      chk_head("sq", 32'h100, 32'h200, 1'b1, 3'd1);
      wr_ready = 1'b1;
      tick();
      chk("sq_pop_occ",   32'(occupancy), 32'd0);
      chk("sq_pop_valid", 32'(wr_valid), 32'd0);

      // Two pushes, order and stall threshold.
      wr_ready = 1'b0;
      set_upd(1'b1, 1'b0, 32'h104, 32'h108, 1'b1, 1'b1, 32'h108, 32'h300);
      tick();
      chk_head("dual", 32'h104, 32'h108, 1'b0, 3'd2);
      chk("dual_stall", 32'(stall_req), 32'd0);
      set_upd(1'b1, 1'b0, 32'h10C, 32'h110, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk_head("third", 32'h104, 32'h108, 1'b0, 3'd3);
      chk("third_stall", 32'(stall_req), 32'd1);
      // Stalled: inputs ignored, payload held.
      set_upd(1'b1, 1'b0, 32'hBAD, 32'hBAD, 1'b1, 1'b0, 32'hBAD4, 32'h0);
      tick();
      chk_head("hold", 32'h104, 32'h108, 1'b0, 3'd3);
      clr_upd();
      wr_ready = 1'b1;
      tick();
      chk_head("pop1", 32'h108, 32'h300, 1'b1, 3'd2);
      tick();
      chk_head("pop2", 32'h10C, 32'h110, 1'b0, 3'd1);
      tick();
      chk("pop3_occ",   32'(occupancy), 32'd0);
      chk("pop3_valid", 32'(wr_valid), 32'd0);

      // Push 2 while popping 1, across the pointer wrap.
      wr_ready = 1'b0;
      set_upd(1'b1, 1'b0, 32'h400, 32'h404, 1'b1, 1'b1, 32'h404, 32'h480);
      tick();
      chk_head("pp0", 32'h400, 32'h404, 1'b0, 3'd2);
      wr_ready = 1'b1;
      set_upd(1'b1, 1'b0, 32'h408, 32'h40C, 1'b1, 1'b0, 32'h40C, 32'h410);
      tick();
      chk_head("pp1", 32'h404, 32'h480, 1'b1, 3'd3);
      chk("pp1_stall", 32'(stall_req), 32'd1);
      set_upd(1'b1, 1'b0, 32'hBAD, 32'hBAD, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk_head("pp2", 32'h408, 32'h40C, 1'b0, 3'd2);
      set_upd(1'b1, 1'b0, 32'h410, 32'h414, 1'b1, 1'b1, 32'h414, 32'h4F0);
      tick();
      clr_upd();
      chk_head("pp3", 32'h40C, 32'h410, 1'b0, 3'd3);
      tick();
      chk_head("pp4", 32'h410, 32'h414, 1'b0, 3'd2);
      tick();
      chk_head("pp5", 32'h414, 32'h4F0, 1'b1, 3'd1);
      tick();
      chk("pp6_occ", 32'(occupancy), 32'd0);

      // Reset with a full-ish queue discards entries and restarts INIT.
      wr_ready = 1'b0;
      set_upd(1'b1, 1'b0, 32'h500, 32'h0, 1'b1, 1'b0, 32'h504, 32'h0);
      tick();
      set_upd(1'b1, 1'b0, 32'h508, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      clr_upd();
      chk("prerst_occ", 32'(occupancy), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst_occ",   32'(occupancy), 32'd0);
      chk("mrst_clr",   32'(wr_clr), 32'd1);
      chk("mrst_pc",    wr_pc, 32'd0);
      chk("mrst_stall", 32'(stall_req), 32'd1);
      // Without wr_ready the init index must not advance.
      tick();
      chk("mrst_hold_pc", wr_pc, 32'd0);
      wr_ready = 1'b1;
      run_init("reinit");
      tick();
      chk("post_valid", 32'(wr_valid), 32'd0);
      chk("post_occ",   32'(occupancy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
